// File: rtl/rf_wr_arb.sv
// Register-file write-port arbiter: pipeline writeback (P) has fixed priority,
// and the long-latency unit (L) is forced through after STARVE_MAX denied cycles.
// The winner of each valid/ready handshake is registered onto the rf write port.
module rf_wr_arb #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_valid,
    input  logic [ADDR_W-1:0] p_rd,
    input  logic [DATA_W-1:0] p_data,
    output logic              p_ready,
    input  logic              l_valid,
    input  logic [ADDR_W-1:0] l_rd,
    input  logic [DATA_W-1:0] l_data,
    output logic              l_ready,
    output logic              rf_write_e,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_write_d,
    output logic              l_pri
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic {PIPE_PRI, LONG_PRI} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             grant_p, grant_l;
    wr_req_t          win;

    // Grants, winner mux, starvation count and next state.
    // Reset gates both grants so nothing is accepted during the reset cycle.
    always_comb begin
        grant_p   = 1'b0;
        grant_l   = 1'b0;
        win       = '{rd: p_rd, data: p_data};
        cnt_nxt   = '0;
        state_nxt = state;
        if (!rst) begin
            grant_p = p_valid & ((state == PIPE_PRI) | !l_valid);
            grant_l = l_valid & !grant_p;
        end
        if (grant_l)
            win = '{rd: l_rd, data: l_data};
        // Saturating count of consecutive cycles L was left waiting
        if (l_valid && !grant_l)
            cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        case (state)
            PIPE_PRI: if (cnt_nxt == CNT_MAX) state_nxt = LONG_PRI;
            LONG_PRI: if (grant_l || !l_valid) state_nxt = PIPE_PRI;
            default:  state_nxt = PIPE_PRI;
        endcase
    end

    assign p_ready = grant_p;
    assign l_ready = grant_l;
    assign l_pri   = (state == LONG_PRI);

    // FSM state and starvation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PIPE_PRI;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Register the winning write; x0 transfers are accepted but never written,
    // and the address/data hold their last real write in that case.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_write_e <= 1'b0;
            rf_rd      <= '0;
            rf_write_d <= '0;
        end else if ((grant_p || grant_l) && (win.rd != '0)) begin
            rf_write_e <= 1'b1;
            rf_rd      <= win.rd;
            rf_write_d <= win.data;
        end else begin
            rf_write_e <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rf_wr_arb.sv
// Directed vector table, reset/starvation sequences and a randomised
// protocol-following run checked against a small priority model.
module tb_rf_wr_arb;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int STARVE_MAX = 4;
    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic              clk = 1'b0;
    logic              rst;
    logic              p_valid, l_valid;
    logic [ADDR_W-1:0] p_rd, l_rd;
    logic [DATA_W-1:0] p_data, l_data;
    logic              p_ready, l_ready, rf_write_e, l_pri;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_write_d;

    int n_total = 0;
    int n_pass  = 0;

    rf_wr_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .p_valid(p_valid), .p_rd(p_rd), .p_data(p_data), .p_ready(p_ready),
        .l_valid(l_valid), .l_rd(l_rd), .l_data(l_data), .l_ready(l_ready),
        .rf_write_e(rf_write_e), .rf_rd(rf_rd), .rf_write_d(rf_write_d),
        .l_pri(l_pri)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              pv;
        logic [ADDR_W-1:0] prd;
        logic [DATA_W-1:0] pd;
        logic              lv;
        logic [ADDR_W-1:0] lrd;
        logic [DATA_W-1:0] ld;
        logic              e_pr;
        logic              e_lr;
        logic              e_lpri;
        logic              e_we;
        logic              chk_rf;
        logic [ADDR_W-1:0] e_rd;
        logic [DATA_W-1:0] e_wd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic drive(input logic pv, input logic [ADDR_W-1:0] prd, input logic [DATA_W-1:0] pd,
                         input logic lv, input logic [ADDR_W-1:0] lrd, input logic [DATA_W-1:0] ld);
        p_valid = pv; p_rd = prd; p_data = pd;
        l_valid = lv; l_rd = lrd; l_data = ld;
    endtask

    initial begin
        logic              pp, lp, exp_p, exp_l, exp_we;
        logic [ADDR_W-1:0] prd_r, lrd_r, xrd;
        logic [DATA_W-1:0] pd_r, ld_r, xd;
        int                lwait;
        logic [DATA_W-1:0] seq;

        // Row: P, L request; then ready/pri this cycle; then write port next cycle
        vecs.push_back('{T, 5'd5, 32'hDEADBEEF, F, 5'd0, 32'h0,    T, F, F, T, T, 5'd5, 32'hDEADBEEF});
        vecs.push_back('{F, 5'd0, 32'h0,        F, 5'd0, 32'h0,    F, F, F, F, T, 5'd5, 32'hDEADBEEF});
        vecs.push_back('{F, 5'd0, 32'h0,        T, 5'd0, 32'h1234, F, T, F, F, F, 5'd0, 32'h0});
        vecs.push_back('{T, 5'd3, 32'h33,       T, 5'd7, 32'h77,   T, F, F, T, T, 5'd3, 32'h33});
        vecs.push_back('{F, 5'd0, 32'h0,        T, 5'd7, 32'h77,   F, T, F, T, T, 5'd7, 32'h77});
        vecs.push_back('{T, 5'd1, 32'h100,      T, 5'd2, 32'h200,  T, F, F, T, T, 5'd1, 32'h100});
        vecs.push_back('{T, 5'd1, 32'h101,      T, 5'd2, 32'h200,  T, F, F, T, T, 5'd1, 32'h101});
        vecs.push_back('{T, 5'd1, 32'h102,      T, 5'd2, 32'h200,  T, F, F, T, T, 5'd1, 32'h102});
        vecs.push_back('{T, 5'd1, 32'h103,      T, 5'd2, 32'h200,  T, F, F, T, T, 5'd1, 32'h103});
        vecs.push_back('{T, 5'd1, 32'h104,      T, 5'd2, 32'h200,  F, T, T, T, T, 5'd2, 32'h200});
        vecs.push_back('{T, 5'd1, 32'h104,      F, 5'd0, 32'h0,    T, F, F, T, T, 5'd1, 32'h104});
        vecs.push_back('{T, 5'd1, 32'h105,      T, 5'd4, 32'h400,  T, F, F, T, T, 5'd1, 32'h105});
        vecs.push_back('{F, 5'd0, 32'h0,        T, 5'd4, 32'h400,  F, T, F, T, T, 5'd4, 32'h400});
        vecs.push_back('{T, 5'd6, 32'h61,       T, 5'd6, 32'h62,   T, F, F, T, T, 5'd6, 32'h61});
        vecs.push_back('{F, 5'd0, 32'h0,        T, 5'd6, 32'h62,   F, T, F, T, T, 5'd6, 32'h62});
        vecs.push_back('{F, 5'd0, 32'h0,        F, 5'd0, 32'h0,    F, F, F, F, T, 5'd6, 32'h62});

        // Power-on reset
        rst = 1'b1;
        drive(F, '0, '0, F, '0, '0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("reset_we",    32'(rf_write_e), 32'd0);
        chk("reset_rd",    32'(rf_rd),      32'd0);
        chk("reset_wd",    rf_write_d,      32'd0);
        chk("reset_lpri",  32'(l_pri),      32'd0);

        // Directed vectors, one row per cycle
        foreach (vecs[i]) begin
            drive(vecs[i].pv, vecs[i].prd, vecs[i].pd, vecs[i].lv, vecs[i].lrd, vecs[i].ld);
            #1;
            chk($sformatf("vec%0d_p_ready", i), 32'(p_ready), 32'(vecs[i].e_pr));
            chk($sformatf("vec%0d_l_ready", i), 32'(l_ready), 32'(vecs[i].e_lr));
            chk($sformatf("vec%0d_l_pri", i),   32'(l_pri),   32'(vecs[i].e_lpri));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_we", i), 32'(rf_write_e), 32'(vecs[i].e_we));
            if (vecs[i].chk_rf) begin
                chk($sformatf("vec%0d_rd", i), 32'(rf_rd), 32'(vecs[i].e_rd));
                chk($sformatf("vec%0d_wd", i), rf_write_d, vecs[i].e_wd);
            end
        end

        // Build up L starvation, then reset alongside a P transfer of x9
        for (int i = 0; i < 2; i++) begin
            drive(T, 5'd1, 32'h500 + 32'(i), T, 5'd2, 32'h600);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        drive(T, 5'd9, 32'h99, T, 5'd2, 32'h600);
        #1;
        chk("rst_p_ready", 32'(p_ready), 32'd0);
        chk("rst_l_ready", 32'(l_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(F, '0, '0, F, '0, '0);
        #1;
        chk("post_rst_we",   32'(rf_write_e), 32'd0);
        chk("post_rst_rd",   32'(rf_rd),      32'd0);
        chk("post_rst_wd",   rf_write_d,      32'd0);
        chk("post_rst_lpri", 32'(l_pri),      32'd0);
        @(posedge clk); #1;
        chk("post_rst_no_x9", 32'(rf_write_e), 32'd0);

        // Counter must restart from zero: L waits the full STARVE_MAX cycles again
        for (int i = 0; i <= STARVE_MAX; i++) begin
            drive(T, 5'd1, 32'h700 + 32'(i), T, 5'd2, 32'h800);
            #1;
            chk($sformatf("restarve%0d_l_ready", i), 32'(l_ready), 32'(i == STARVE_MAX));
            @(posedge clk); #1;
        end

        // Randomised traffic that follows the handshake rules
        pp = 1'b0; lp = 1'b0; lwait = 0; seq = 32'h1000;
        prd_r = '0; lrd_r = '0; pd_r = '0; ld_r = '0;
        for (int c = 0; c < 10000; c++) begin
            if (!pp && $urandom_range(0, 3) != 0) begin
                pp = 1'b1; prd_r = ADDR_W'($urandom_range(0, 31)); pd_r = seq; seq++;
            end
            if (!lp && $urandom_range(0, 1) != 0) begin
                lp = 1'b1; lrd_r = ADDR_W'($urandom_range(0, 31)); ld_r = seq; seq++;
            end
            drive(pp, prd_r, pd_r, lp, lrd_r, ld_r);
            #1;
            exp_l = lp && (!pp || lwait == STARVE_MAX);
            exp_p = pp && !exp_l;
            chk("rnd_grant", 32'({p_ready, l_ready, l_pri}),
                32'({exp_p, exp_l, (lwait == STARVE_MAX)}));
            xrd = exp_l ? lrd_r : prd_r;
            xd  = exp_l ? ld_r  : pd_r;
            if (lp && !exp_l) lwait++;
            else              lwait = 0;
            @(posedge clk); #1;
            exp_we = (exp_p || exp_l) && (xrd != '0);
            chk("rnd_we", 32'(rf_write_e), 32'(exp_we));
            if (exp_we) begin
                chk("rnd_rd", 32'(rf_rd), 32'(xrd));
                chk("rnd_wd", rf_write_d, xd);
            end
            if (exp_p) pp = 1'b0;
            if (exp_l) lp = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
